// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA timing generator and the receive-side
// timing recovery block.
//   - COUNT_W            : width of all column/row/measurement counters
//   - H_TOTAL / V_TOTAL  : 640x480@60 clocks per line and lines per frame
//   - H_ACTIVE / V_ACTIVE: visible columns and rows of the same mode
//   - sync_state_e       : recovery state machine encoding
//   - sat_inc()          : counter increment that sticks at all-ones
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int COUNT_W  = 10;
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_e;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (value == COUNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// ---------------------------------------------------------------------------
// vga_edge_detect
// Rising-edge detector for a level-type sync input.
//   clock   : pixel clock
//   reset_n : asynchronous active-low reset
//   sig_i   : sync level to watch
//   rise_o  : high for the clock in which sig_i is high and was low before
// The history register resets to 1, so a sync that is already high when
// reset is released does not look like an edge; the first rise reported is
// the next genuine low-to-high transition.
// ---------------------------------------------------------------------------
module vga_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/vga_sync_timing_recovery.sv
// ---------------------------------------------------------------------------
// vga_sync_timing_recovery
// Recovers column/row position from level-type Hsync/Vsync (high = active),
// checks the stream against the expected geometry and reports lock.
//   clock           : pixel clock
//   reset_n         : asynchronous active-low reset
//   in_Hsync        : high during active columns, rise = column 0
//   in_Vsync        : high during active rows, rise = row 0
//   out_Hsync/Vsync : inputs delayed one clock
//   column_count    : recovered column, aligned with out_Hsync
//   row_count       : recovered row, aligned with out_Vsync
//   out_locked      : stream verified and being tracked
//   out_line_length : clocks between the last two Hsync rises (sat. 1023)
//   out_frame_lines : Hsync rises between the last two Vsync rises (sat. 1023)
//   out_error_count : number of lock losses (saturating)
// ---------------------------------------------------------------------------
module vga_sync_timing_recovery
    import vga_timing_pkg::*;
#(
    parameter int TOTAL_COLS  = H_TOTAL,
    parameter int TOTAL_ROWS  = V_TOTAL,
    parameter int LOCK_FRAMES = 2,
    parameter int ERR_W       = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_Hsync,
    input  logic               in_Vsync,
    output logic               out_Hsync,
    output logic               out_Vsync,
    output logic [9:0]         column_count,
    output logic [9:0]         row_count,
    output logic               out_locked,
    output logic [9:0]         out_line_length,
    output logic [9:0]         out_frame_lines,
    output logic [ERR_W-1:0]   out_error_count
);

    localparam logic [COUNT_W-1:0] LAST_COL    = COUNT_W'(TOTAL_COLS - 1);
    localparam logic [COUNT_W-1:0] LAST_ROW    = COUNT_W'(TOTAL_ROWS - 1);
    localparam logic [3:0]         LOCK_TARGET = 4'(LOCK_FRAMES);

    logic h_rise, v_rise;

    vga_edge_detect u_h_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .sig_i   (in_Hsync),
        .rise_o  (h_rise)
    );

    vga_edge_detect u_v_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .sig_i   (in_Vsync),
        .rise_o  (v_rise)
    );

    logic                hsync_q, vsync_q;
    logic [COUNT_W-1:0]  column_q, row_q, column_d, row_d;
    logic [COUNT_W-1:0]  line_cyc_q, line_len_q, frame_line_q, frame_lines_q;
    logic                exp_h, exp_v, mismatch, line_end;
    logic [COUNT_W-1:0]  row_adv;
    sync_state_e         state_q;
    logic [3:0]          clean_q;
    logic                locked_q;
    logic [ERR_W-1:0]    err_q;

    // A line ends either on a real Hsync rise or, if the rise is missing,
    // when the flywheel reaches the last column. A Vsync rise forces row 0.
    always_comb begin
        exp_h    = (column_q == LAST_COL);
        exp_v    = exp_h && (row_q == LAST_ROW);
        mismatch = (h_rise != exp_h) || (v_rise != exp_v) || (v_rise && !h_rise);
        line_end = h_rise || exp_h;
        row_adv  = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
        column_d = line_end ? '0 : column_q + 1'b1;
        row_d    = row_q;
        if (v_rise) begin
            row_d = '0;
        end else if (line_end) begin
            row_d = row_adv;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            column_q <= '0;
            row_q    <= '0;
        end else begin
            hsync_q  <= in_Hsync;
            vsync_q  <= in_Vsync;
            column_q <= column_d;
            row_q    <= row_d;
        end
    end

    // Line length counts clocks from one Hsync rise to the next; frame
    // length counts Hsync rises from one Vsync rise to the next. The Hsync
    // rise coinciding with the Vsync rise is line 1 of the new frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_cyc_q    <= '0;
            line_len_q    <= '0;
            frame_line_q  <= '0;
            frame_lines_q <= '0;
        end else begin
            if (h_rise) begin
                line_cyc_q <= COUNT_W'(1);
                line_len_q <= line_cyc_q;
            end else begin
                line_cyc_q <= sat_inc(line_cyc_q);
            end
            if (v_rise) begin
                frame_line_q  <= COUNT_W'(1);
                frame_lines_q <= frame_line_q;
            end else if (h_rise) begin
                frame_line_q <= sat_inc(frame_line_q);
            end
        end
    end

    // locked_q is loaded with the next-state decode so that it rises
    // together with the 0,0 count of the locking frame and drops in the
    // cycle right after the offending sample. Mismatch wins over a Vsync
    // rise arriving in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SEARCH;
            clean_q  <= '0;
            locked_q <= 1'b0;
            err_q    <= '0;
        end else begin
            case (state_q)
                SEARCH: begin
                    locked_q <= 1'b0;
                    if (v_rise && h_rise) begin
                        state_q <= VERIFY;
                        clean_q <= '0;
                    end
                end
                VERIFY: begin
                    if (mismatch) begin
                        state_q <= SEARCH;
                    end else if (v_rise) begin
                        clean_q <= clean_q + 4'd1;
                        if (clean_q + 4'd1 == LOCK_TARGET) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (mismatch) begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                        if (err_q != '1) begin
                            err_q <= err_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_Hsync       = hsync_q;
    assign out_Vsync       = vsync_q;
    assign column_count    = column_q;
    assign row_count       = row_q;
    assign out_locked      = locked_q;
    assign out_line_length = line_len_q;
    assign out_frame_lines = frame_lines_q;
    assign out_error_count = err_q;

endmodule

// File: tb/tb_vga_sync_timing_recovery.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_timing_recovery
// Directed bench for the timing recovery block using a reduced 20x8 raster
// (16 active columns, 6 active rows) so several frames fit in a short run.
// A source position (src_col, src_row) drives the syncs; after each clock
// the recovered counts are expected to equal the position just sampled.
// ---------------------------------------------------------------------------
module tb_vga_sync_timing_recovery;

    localparam int TC    = 20;
    localparam int TR    = 8;
    localparam int ACT_C = 16;
    localparam int ACT_R = 6;

    logic       clock;
    logic       reset_n;
    logic       in_Hsync;
    logic       in_Vsync;
    logic       out_Hsync;
    logic       out_Vsync;
    logic [9:0] column_count;
    logic [9:0] row_count;
    logic       out_locked;
    logic [9:0] out_line_length;
    logic [9:0] out_frame_lines;
    logic [1:0] out_error_count;

    int passed = 0;
    int total  = 0;

    int src_col  = 0;
    int src_row  = 0;
    int src_cols = TC;
    bit track_en = 1'b0;
    int track_bad = 0;
    bit ever_locked = 1'b0;

    vga_sync_timing_recovery #(
        .TOTAL_COLS  (TC),
        .TOTAL_ROWS  (TR),
        .LOCK_FRAMES (2),
        .ERR_W       (2)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .in_Hsync        (in_Hsync),
        .in_Vsync        (in_Vsync),
        .out_Hsync       (out_Hsync),
        .out_Vsync       (out_Vsync),
        .column_count    (column_count),
        .row_count       (row_count),
        .out_locked      (out_locked),
        .out_line_length (out_line_length),
        .out_frame_lines (out_frame_lines),
        .out_error_count (out_error_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One pixel clock of source: drive syncs for the current position
    // (kill forces Hsync low), clock it in, then advance the position.
    task automatic step(input bit kill);
        logic h, v;
        int c, r;
        c = src_col;
        r = src_row;
        h = (c < ACT_C) && !kill;
        v = (r < ACT_R);
        in_Hsync = h;
        in_Vsync = v;
        @(posedge clock);
        #1;
        if (out_locked === 1'b1) ever_locked = 1'b1;
        if (track_en && (column_count !== 10'(c) || row_count !== 10'(r) ||
                         out_Hsync !== h || out_Vsync !== v)) begin
            track_bad++;
        end
        src_col = c + 1;
        if (src_col >= src_cols) begin
            src_col = 0;
            src_row = (r + 1) % TR;
        end
    endtask

    task automatic run_to(input int col, input int row);
        for (int n = 0; n < 5000; n++) begin
            if (src_col == col && src_row == row) break;
            step(1'b0);
        end
    endtask

    // Reset with syncs low and the source parked two clocks before a frame.
    task automatic do_reset();
        track_en = 1'b0;
        reset_n  = 1'b0;
        in_Hsync = 1'b0;
        in_Vsync = 1'b0;
        src_col  = src_cols - 2;
        src_row  = TR - 1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // Three frame starts after reset: search->verify, one clean, lock.
    task automatic lock_from_reset();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            run_to(0, 0);
            step(1'b0);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        in_Hsync = 1'b1;
        in_Vsync = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        total++; if (column_count !== 10'd0) $display("[TB] FAIL reset_col: got %0d expected 0", column_count); else passed++;
        total++; if (row_count !== 10'd0) $display("[TB] FAIL reset_row: got %0d expected 0", row_count); else passed++;
        total++; if (out_locked !== 1'b0) $display("[TB] FAIL reset_locked: got %0b expected 0", out_locked); else passed++;
        total++; if (out_Hsync !== 1'b0 || out_Vsync !== 1'b0) $display("[TB] FAIL reset_syncs: got %0b%0b expected 00", out_Hsync, out_Vsync); else passed++;
        total++; if (out_line_length !== 10'd0 || out_frame_lines !== 10'd0) $display("[TB] FAIL reset_meas: got %0d/%0d expected 0/0", out_line_length, out_frame_lines); else passed++;
        total++; if (out_error_count !== 2'd0) $display("[TB] FAIL reset_err: got %0d expected 0", out_error_count); else passed++;
    endtask

    task automatic test_lock();
        do_reset();
        run_to(0, 0);
        step(1'b0);
        track_en  = 1'b1;
        track_bad = 0;
        run_to(0, 0);
        step(1'b0);
        total++; if (out_locked !== 1'b0) $display("[TB] FAIL lock_early: got %0b expected 0", out_locked); else passed++;
        run_to(0, 0);
        total++; if (out_locked !== 1'b0) $display("[TB] FAIL lock_before3: got %0b expected 0", out_locked); else passed++;
        step(1'b0);
        total++; if (out_locked !== 1'b1) $display("[TB] FAIL lock_at3: got %0b expected 1", out_locked); else passed++;
        total++; if (column_count !== 10'd0 || row_count !== 10'd0) $display("[TB] FAIL lock_pos: got %0d,%0d expected 0,0", column_count, row_count); else passed++;
        total++; if (out_line_length !== 10'd20) $display("[TB] FAIL line_length: got %0d expected 20", out_line_length); else passed++;
        total++; if (out_frame_lines !== 10'd8) $display("[TB] FAIL frame_lines: got %0d expected 8", out_frame_lines); else passed++;
        ever_locked = 1'b0;
        run_to(0, 0);
        step(1'b0);
        total++; if (out_locked !== 1'b1) $display("[TB] FAIL lock_held: got %0b expected 1", out_locked); else passed++;
        total++; if (track_bad !== 0) $display("[TB] FAIL track: got %0d bad cycles expected 0", track_bad); else passed++;
        track_en = 1'b0;
    endtask

    task automatic test_glitch();
        lock_from_reset();
        run_to(5, 2);
        step(1'b1);
        step(1'b0);
        total++; if (out_locked !== 1'b0) $display("[TB] FAIL glitch_unlock: got %0b expected 0", out_locked); else passed++;
        total++; if (out_error_count !== 2'd1) $display("[TB] FAIL glitch_err: got %0d expected 1", out_error_count); else passed++;
        total++; if (column_count !== 10'd0 || row_count !== 10'd3) $display("[TB] FAIL glitch_pos: got %0d,%0d expected 0,3", column_count, row_count); else passed++;
        run_to(0, 0);
        step(1'b0);
        run_to(0, 0);
        step(1'b0);
        run_to(0, 0);
        total++; if (out_locked !== 1'b0) $display("[TB] FAIL glitch_relock_early: got %0b expected 0", out_locked); else passed++;
        step(1'b0);
        total++; if (out_locked !== 1'b1) $display("[TB] FAIL glitch_relock: got %0b expected 1", out_locked); else passed++;
    endtask

    task automatic test_missing_edge();
        lock_from_reset();
        run_to(19, 2);
        step(1'b0);
        total++; if (column_count !== 10'd19) $display("[TB] FAIL miss_pre: got %0d expected 19", column_count); else passed++;
        step(1'b1);
        total++; if (column_count !== 10'd0 || row_count !== 10'd3) $display("[TB] FAIL miss_wrap: got %0d,%0d expected 0,3", column_count, row_count); else passed++;
        total++; if (out_locked !== 1'b0) $display("[TB] FAIL miss_unlock: got %0b expected 0", out_locked); else passed++;
        total++; if (out_error_count !== 2'd1) $display("[TB] FAIL miss_err: got %0d expected 1", out_error_count); else passed++;
        while (src_col != 0) step(1'b1);
        step(1'b0);
        total++; if (column_count !== 10'd0 || row_count !== 10'd4) $display("[TB] FAIL miss_next: got %0d,%0d expected 0,4", column_count, row_count); else passed++;
    endtask

    task automatic test_mid_reset();
        lock_from_reset();
        run_to(5, 2);
        step(1'b0);
        reset_n = 1'b0;
        #1;
        total++; if (out_locked !== 1'b0 || out_Hsync !== 1'b0 || out_Vsync !== 1'b0) $display("[TB] FAIL midrst_flags: got %0b%0b%0b expected 000", out_locked, out_Hsync, out_Vsync); else passed++;
        total++; if (column_count !== 10'd0 || row_count !== 10'd0) $display("[TB] FAIL midrst_pos: got %0d,%0d expected 0,0", column_count, row_count); else passed++;
        total++; if (out_line_length !== 10'd0 || out_frame_lines !== 10'd0) $display("[TB] FAIL midrst_meas: got %0d/%0d expected 0/0", out_line_length, out_frame_lines); else passed++;
        #1;
        reset_n = 1'b1;
        run_to(0, 3);
        total++; if (column_count !== 10'd14) $display("[TB] FAIL midrst_norise: got %0d expected 14", column_count); else passed++;
        step(1'b0);
        total++; if (column_count !== 10'd0 || row_count !== 10'd1) $display("[TB] FAIL midrst_rise: got %0d,%0d expected 0,1", column_count, row_count); else passed++;
        run_to(0, 0);
        step(1'b0);
        run_to(0, 0);
        step(1'b0);
        run_to(0, 0);
        total++; if (out_locked !== 1'b0) $display("[TB] FAIL midrst_early: got %0b expected 0", out_locked); else passed++;
        step(1'b0);
        total++; if (out_locked !== 1'b1) $display("[TB] FAIL midrst_relock: got %0b expected 1", out_locked); else passed++;
    endtask

    task automatic test_wrong_width();
        src_cols = TC + 1;
        do_reset();
        ever_locked = 1'b0;
        for (int f = 0; f < 4; f++) begin
            run_to(0, 0);
            step(1'b0);
        end
        step(1'b0);
        total++; if (ever_locked !== 1'b0) $display("[TB] FAIL wide_locked: got %0b expected 0", ever_locked); else passed++;
        total++; if (out_line_length !== 10'd21) $display("[TB] FAIL wide_len: got %0d expected 21", out_line_length); else passed++;
        total++; if (out_frame_lines !== 10'd8) $display("[TB] FAIL wide_lines: got %0d expected 8", out_frame_lines); else passed++;
        total++; if (out_error_count !== 2'd0) $display("[TB] FAIL wide_err: got %0d expected 0", out_error_count); else passed++;
        src_cols = TC;
    endtask

    task automatic test_err_saturate();
        int expected;
        lock_from_reset();
        for (int i = 1; i <= 5; i++) begin
            run_to(5, 2);
            step(1'b1);
            step(1'b0);
            expected = (i > 3) ? 3 : i;
            total++; if (out_error_count !== 2'(expected)) $display("[TB] FAIL err_sat_%0d: got %0d expected %0d", i, out_error_count, expected); else passed++;
            for (int f = 0; f < 3; f++) begin
                run_to(0, 0);
                step(1'b0);
            end
            total++; if (out_locked !== 1'b1) $display("[TB] FAIL err_relock_%0d: got %0b expected 1", i, out_locked); else passed++;
        end
    endtask

    task automatic test_line_saturate();
        lock_from_reset();
        run_to(0, 1);
        for (int n = 0; n < 1100; n++) step(1'b1);
        while (src_col != 0) step(1'b1);
        step(1'b0);
        total++; if (out_line_length !== 10'd1023) $display("[TB] FAIL len_sat: got %0d expected 1023", out_line_length); else passed++;
        total++; if (out_locked !== 1'b0) $display("[TB] FAIL len_unlock: got %0b expected 0", out_locked); else passed++;
        while (src_col != 0) step(1'b0);
        step(1'b0);
        total++; if (out_line_length !== 10'd20) $display("[TB] FAIL len_recover: got %0d expected 20", out_line_length); else passed++;
    endtask

    initial begin
        reset_n  = 1'b0;
        in_Hsync = 1'b0;
        in_Vsync = 1'b0;
        test_reset();
        test_lock();
        test_glitch();
        test_missing_edge();
        test_mid_reset();
        test_wrong_width();
        test_err_saturate();
        test_line_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_sync_timing_recovery.md
Name: vga_sync_timing_recovery

Overview:
- Receive-side counterpart of the VGA sync generator: takes level-type Hsync/Vsync (high = active columns/rows) and recovers column/row counters.
- Aligned sync copies, lock status, measured line/frame geometry and an error count are produced.
- Sits at the input of any block consuming an external or looped-back VGA timing stream: frame grabber, overlay, timing checker.

Parameters:
- TOTAL_COLS, 800, expected clocks per line.
- TOTAL_ROWS, 525, expected lines per frame.
- LOCK_FRAMES, 2, consecutive clean frames required before lock (1..15).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clock  in  1  pixel clock, 25 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- in_Hsync  in  1  high during active columns; rising edge marks column 0.
- in_Vsync  in  1  high during active rows; rising edge marks row 0, coincident with an Hsync rise.
- out_Hsync  out  1  in_Hsync delayed 1 clock.
- out_Vsync  out  1  in_Vsync delayed 1 clock.
- column_count  out  10  recovered column, aligned with out_Hsync.
- row_count  out  10  recovered row, aligned with out_Vsync.
- out_locked  out  1  timing verified and tracking.
- out_line_length  out  10  clocks between the last two Hsync rises; saturates at 1023.
- out_frame_lines  out  10  Hsync rises between the last two Vsync rises; saturates at 1023.
- out_error_count  out  ERR_W  lock-loss events; saturating.

Behaviour:
- Reset values: all outputs 0; state SEARCH; internal edge-history registers h_prev and v_prev reset to 1, so a sync already high at reset release is not treated as an edge.
- Edge detection:
  - h_rise = in_Hsync & ~h_prev; v_rise = in_Vsync & ~v_prev.
  - h_prev, v_prev, out_Hsync and out_Vsync all load their inputs every clock.
- Counters (flywheel), updated every clock. Total latency is 1 clock: counts equal the source counts delayed by one.
  - On h_rise: column_count <= 0 and row_count <= row_count+1, wrapping to 0 after TOTAL_ROWS-1.
  - Else if column_count == TOTAL_COLS-1: column_count <= 0 and row advances as above (missing edge).
  - Else: column_count <= column_count+1.
  - On v_rise: row_count <= 0, overriding the row advance.
- Mismatch, evaluated each clock (exp_h = column_count==TOTAL_COLS-1; exp_v = exp_h & row_count==TOTAL_ROWS-1):
  - h_rise != exp_h, or
  - v_rise != exp_v, or
  - v_rise without h_rise.
- State machine:
  - SEARCH: on v_rise & h_rise, go to VERIFY with clean-frame count = 0. Mismatches are ignored.
  - VERIFY: on a mismatch, go to SEARCH. On a clean v_rise, clean-frame count++. When the count reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: on a mismatch, go to SEARCH and out_error_count++, saturating at 2^ERR_W-1. Counters keep flywheeling or resyncing as defined above.
- out_locked is a registered decode of state == LOCKED:
  - Rises in the same cycle that column_count and row_count show 0,0 of the locking frame.
  - Falls in the cycle following the mismatch sample.
- Measurement:
  - Line cycle counter resets to 1 on h_rise (else increments, saturating at 1023); its pre-reset value is latched into out_line_length on each h_rise.
  - Line counter works the same way on v_rise, latching into out_frame_lines.
  - Measurements run in every state.
- Simultaneous events: an h_rise coinciding with a flywheel wrap is the normal case, not an error. A v_rise and a mismatch in the same cycle resolve as a mismatch.
- Reset mid-operation returns everything to reset values immediately (async). Relock requires a fresh Vsync rise followed by LOCK_FRAMES clean frames.

Decomposition:
- Shared package (vga_timing_pkg): state encoding (SEARCH, VERIFY, LOCKED), the 640x480 timing constants (800/525/640/480), and the 10-bit count width. The generator also uses these.
- One natural sub-module: vga_edge_detect (registered rise detect, reset-to-1 history), instantiated for H and V.

Test Plan:
1. Ideal 800x525 stream from the generator, reset released at frame start:
   - out_locked rises at the 3rd Vsync rise after reset release (LOCK_FRAMES=2).
   - out_line_length=800 and out_frame_lines=525.
   - column_count and row_count equal the source counts delayed 1 clock throughout.
2. While locked, inject a 1-clock Hsync low/high at column 100, row 10:
   - out_locked falls the next clock; out_error_count=1.
   - column_count reads 0 after the spurious rise.
   - Relock occurs 2 frames after the next Vsync rise.
3. While locked, suppress one Hsync rise (hold Hsync low across a line start):
   - column_count wraps 799->0 and the row advances.
   - out_locked falls; out_error_count=1.
4. Assert reset_n low mid-frame while in_Hsync=1, then release:
   - All outputs read 0.
   - No h_rise until the next genuine line start.
   - out_locked stays low until relock.
5. Source with 801 columns:
   - Never locks; out_line_length=801; out_error_count stays 0.
6. ERR_W=2, force 5 lock-loss events (relocking between them) -> out_error_count saturates at 3.
